pwr_seq_ctrl: RTL

- Single FSM that sequences board power: VCORE → P1V8 → P3V3 → P1V1 → PCIe reset release.
- Replaces the chain of independent per-rail ms delay timers with one counter plus power-good timeout supervision.
- Adds fault handling and an ordered reverse power-down.
- Sits beside the 1 us / 1 ms tick timers and consumes their 1 ms pulse.

---
 rtl/pwr_seq_ctrl.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/pwr_seq_ctrl.sv
// pwr_seq_ctrl - board power sequencer.
//
// Brings the rails up in the order VCORE -> P1V8 -> P3V3 -> P1V1 and then
// releases PCIe reset. One shared ms counter times every inter-rail delay and
// every power-good wait. Losing a confirmed power-good or timing out on one
// latches a fault. Dropping vcore_en walks the rails back down in reverse order.
//
// Ports:
//   sys_clk      in   system clock (50 MHz)
//   sys_rst_n    in   asynchronous active-low reset
//   ms_tick      in   one-cycle 1 ms pulse from the tick timer
//   vcore_en     in   power-on request (level)
//   vcore_pwrgd  in   VCORE power good
//   p1v8_pwrgd   in   P1V8 power good
//   p3v3_pwrgd   in   P3V3 power good
//   p1v1_pwrgd   in   P1V1 power good
//   p1v8_en      out  P1V8 enable
//   p3v3_en      out  P3V3 enable
//   p1v1_en      out  P1V1 enable
//   pcie_rst_n   out  PCIe reset, active low
//   pwr_ok       out  sequence complete
//   fault        out  fault latched
//   fault_code   out  0 none, 1..4 VCORE/P1V8/P3V3/P1V1 timeout, 5 power-good lost
//   seq_state    out  current state encoding
//
// Build option: define PWR_SEQ_AUTO_RETRY_EN to retry the sequence out of
// FAULT automatically, up to RETRY_MAX times, after RETRY_WAIT_MS.
module pwr_seq_ctrl #(
  parameter int CNT_W         = 11,
  parameter int DLY_1V8_MS    = 6,
  parameter int DLY_3V3_MS    = 6,
  parameter int DLY_1V1_MS    = 6,
  parameter int DLY_PERST_MS  = 10,
  parameter int PG_TIMEOUT_MS = 100,
  parameter int OFF_DLY_MS    = 2,
  parameter int RETRY_MAX     = 3,
  parameter int RETRY_WAIT_MS = 500
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       ms_tick,
  input  logic       vcore_en,
  input  logic       vcore_pwrgd,
  input  logic       p1v8_pwrgd,
  input  logic       p3v3_pwrgd,
  input  logic       p1v1_pwrgd,
  output logic       p1v8_en,
  output logic       p3v3_en,
  output logic       p1v1_en,
  output logic       pcie_rst_n,
  output logic       pwr_ok,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [3:0] seq_state
);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_WAIT_VCORE = 4'd1;
  localparam logic [3:0] S_DLY_1V8    = 4'd2;
  localparam logic [3:0] S_WAIT_1V8   = 4'd3;
  localparam logic [3:0] S_DLY_3V3    = 4'd4;
  localparam logic [3:0] S_WAIT_3V3   = 4'd5;
  localparam logic [3:0] S_DLY_1V1    = 4'd6;
  localparam logic [3:0] S_WAIT_1V1   = 4'd7;
  localparam logic [3:0] S_DLY_PERST  = 4'd8;
  localparam logic [3:0] S_ON         = 4'd9;
  localparam logic [3:0] S_PWR_DOWN   = 4'd10;
  localparam logic [3:0] S_FAULT      = 4'd11;

  localparam logic [CNT_W-1:0] T_1V8     = CNT_W'(DLY_1V8_MS);
  localparam logic [CNT_W-1:0] T_3V3     = CNT_W'(DLY_3V3_MS);
  localparam logic [CNT_W-1:0] T_1V1     = CNT_W'(DLY_1V1_MS);
  localparam logic [CNT_W-1:0] T_PERST   = CNT_W'(DLY_PERST_MS);
  localparam logic [CNT_W-1:0] T_TIMEOUT = CNT_W'(PG_TIMEOUT_MS);
  localparam logic [CNT_W-1:0] T_OFF     = CNT_W'(OFF_DLY_MS);

  logic [3:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             p1v8_n, p3v3_n, p1v1_n;
  logic [2:0]       code_n;
  logic             step_clr;
  logic             pg_lost, pg_wait;
  logic [2:0]       wait_code;
  logic [CNT_W-1:0] dly_sel;
  logic             retry_ok;

  // A power-good counts as confirmed once the state that waited for it has
  // been passed; from then on it must stay high until power-down or fault.
  always_comb begin
    pg_lost = 1'b0;
    if (state >= S_DLY_1V8 && state <= S_ON) begin
      pg_lost = !vcore_pwrgd
             || (state >= S_DLY_3V3   && !p1v8_pwrgd)
             || (state >= S_DLY_1V1   && !p3v3_pwrgd)
             || (state >= S_DLY_PERST && !p1v1_pwrgd);
    end
  end

  // Per-state selection of the awaited power-good, its timeout code and the
  // length of the delay state.
  always_comb begin
    pg_wait   = 1'b0;
    wait_code = 3'd0;
    dly_sel   = T_1V8;
    case (state)
      S_WAIT_VCORE: begin pg_wait = vcore_pwrgd; wait_code = 3'd1; end
      S_WAIT_1V8:   begin pg_wait = p1v8_pwrgd;  wait_code = 3'd2; end
      S_WAIT_3V3:   begin pg_wait = p3v3_pwrgd;  wait_code = 3'd3; end
      S_WAIT_1V1:   begin pg_wait = p1v1_pwrgd;  wait_code = 3'd4; end
      S_DLY_3V3:    dly_sel = T_3V3;
      S_DLY_1V1:    dly_sel = T_1V1;
      S_DLY_PERST:  dly_sel = T_PERST;
      default:      dly_sel = T_1V8;
    endcase
  end

`ifdef PWR_SEQ_AUTO_RETRY_EN
  localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] T_RETRY = CNT_W'(RETRY_WAIT_MS);

  logic [RW-1:0] retry_cnt;
  logic          retry_over;

  // Count FAULT entries; once the count would pass RETRY_MAX the sticky
  // over flag blocks further automatic retries until vcore_en drops.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      retry_cnt  <= '0;
      retry_over <= 1'b0;
    end else if (!vcore_en || state_n == S_ON) begin
      retry_cnt  <= '0;
      retry_over <= 1'b0;
    end else if (state_n == S_FAULT && state != S_FAULT) begin
      if (retry_cnt == RW'(RETRY_MAX)) retry_over <= 1'b1;
      else retry_cnt <= retry_cnt + 1'b1;
    end
  end

  assign retry_ok = !retry_over && (cnt >= T_RETRY);
`else
  logic unused_retry;
  assign unused_retry = ^{RETRY_MAX, RETRY_WAIT_MS};
  assign retry_ok     = 1'b0;
`endif

  // Next-state logic. In every powered state a dropped vcore_en wins over
  // power-good loss and timeout, so a user power-off never reports a fault.
  always_comb begin
    state_n  = state;
    step_clr = 1'b0;
    code_n   = fault_code;
    p1v8_n   = p1v8_en;
    p3v3_n   = p3v3_en;
    p1v1_n   = p1v1_en;
    case (state)
      S_IDLE: if (vcore_en) state_n = S_WAIT_VCORE;
      S_WAIT_VCORE, S_WAIT_1V8, S_WAIT_3V3, S_WAIT_1V1: begin
        if (!vcore_en) state_n = S_PWR_DOWN;
        else if (pg_lost) begin state_n = S_FAULT; code_n = 3'd5; end
        else if (pg_wait) state_n = state + 4'd1;
        else if (cnt >= T_TIMEOUT) begin state_n = S_FAULT; code_n = wait_code; end
      end
      S_DLY_1V8, S_DLY_3V3, S_DLY_1V1, S_DLY_PERST: begin
        if (!vcore_en) state_n = S_PWR_DOWN;
        else if (pg_lost) begin state_n = S_FAULT; code_n = 3'd5; end
        else if (cnt >= dly_sel) state_n = state + 4'd1;
      end
      S_ON: begin
        if (!vcore_en) state_n = S_PWR_DOWN;
        else if (pg_lost) begin state_n = S_FAULT; code_n = 3'd5; end
      end
      S_PWR_DOWN: begin
        // Highest enabled rail goes first; rails that were never enabled are
        // simply not found, so they cost no delay.
        if (!(p1v8_en || p3v3_en || p1v1_en)) state_n = S_IDLE;
        else if (cnt >= T_OFF) begin
          step_clr = 1'b1;
          if (p1v1_en) p1v1_n = 1'b0;
          else if (p3v3_en) p3v3_n = 1'b0;
          else p1v8_n = 1'b0;
          if (!(p1v8_n || p3v3_n || p1v1_n)) state_n = S_IDLE;
        end
      end
      S_FAULT: begin
        if (!vcore_en) state_n = S_IDLE;
        else if (retry_ok) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    if (state_n == S_WAIT_1V8) p1v8_n = 1'b1;
    if (state_n == S_WAIT_3V3) p3v3_n = 1'b1;
    if (state_n == S_WAIT_1V1) p1v1_n = 1'b1;
    if (state_n == S_IDLE || state_n == S_FAULT) begin
      p1v8_n = 1'b0;
      p3v3_n = 1'b0;
      p1v1_n = 1'b0;
    end
    if (state_n != S_FAULT) code_n = 3'd0;
  end

  // The shared counter restarts on every state change and on each
  // power-down step, and saturates so a long stay in ON cannot wrap it.
  always_comb begin
    cnt_n = cnt;
    if (state_n != state || step_clr) cnt_n = '0;
    else if (ms_tick && cnt != '1) cnt_n = cnt + 1'b1;
  end

  // All outputs are registered from the next state so they change on the
  // same edge as the state itself.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      p1v8_en    <= 1'b0;
      p3v3_en    <= 1'b0;
      p1v1_en    <= 1'b0;
      pcie_rst_n <= 1'b0;
      pwr_ok     <= 1'b0;
      fault      <= 1'b0;
      fault_code <= 3'd0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      p1v8_en    <= p1v8_n;
      p3v3_en    <= p3v3_n;
      p1v1_en    <= p1v1_n;
      pcie_rst_n <= (state_n == S_ON);
      pwr_ok     <= (state_n == S_ON);
      fault      <= (state_n == S_FAULT);
      fault_code <= code_n;
    end
  end

  assign seq_state = state;

endmodule
